// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, memory and stall signals around the unified memory port arbiter.
// The arbiter takes the slave view; the surrounding core/memory environment takes the master view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic                  if_flush;
    logic                  if_valid;
    logic [DATA_W-1:0]     if_rdata;

    logic                  dm_req;
    logic                  dm_we;
    logic [ADDR_W-1:0]     dm_addr;
    logic [DATA_W-1:0]     dm_wdata;
    logic [DATA_W/8-1:0]   dm_wstrb;
    logic                  dm_valid;
    logic [DATA_W-1:0]     dm_rdata;

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_wstrb;
    logic                  mem_gnt;
    logic                  mem_rvalid;
    logic [DATA_W-1:0]     mem_rdata;

    logic                  stall_f;
    logic                  stall_m;

    modport master (
        output if_req, if_addr, if_flush,
        output dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  if_valid, if_rdata, dm_valid, dm_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  stall_f, stall_m
    );

    modport slave (
        input  if_req, if_addr, if_flush,
        input  dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output if_valid, if_rdata, dm_valid, dm_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output stall_f, stall_m
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the data stage, one transaction in flight,
// data first with a bounded number of data wins while a fetch is waiting.
module mem_port_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int STARVE_MAX = 4
) (
    input logic               clk,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);
    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    typedef enum logic {OWN_I, OWN_D} owner_t;

    state_t              state, state_nxt;
    owner_t              owner;
    logic                drop_i;
    logic [CNT_W-1:0]    starve_cnt;
    logic                pick_d, pick_i;
    logic                resp;

    logic                mem_req_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [STRB_W-1:0]   mem_wstrb_q;

    always_comb begin
        pick_d = bus.dm_req && (!bus.if_req || (starve_cnt < CNT_MAX));
        pick_i = !pick_d && bus.if_req;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_d || pick_i) state_nxt = ISSUE;
            ISSUE:   if (bus.mem_gnt)      state_nxt = WAIT;
            WAIT:    if (bus.mem_rvalid)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Payload, ownership, starvation count and the flush-drop flag all change only at decision points.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner       <= OWN_I;
            drop_i      <= 1'b0;
            starve_cnt  <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    drop_i <= 1'b0;
                    if (pick_d) begin
                        owner       <= OWN_D;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= bus.dm_we;
                        mem_addr_q  <= bus.dm_addr;
                        mem_wdata_q <= bus.dm_wdata;
                        mem_wstrb_q <= bus.dm_wstrb;
                        if (!bus.if_req)
                            starve_cnt <= '0;
                        else if (starve_cnt != CNT_MAX)
                            starve_cnt <= starve_cnt + 1'b1;
                    end else if (pick_i) begin
                        owner       <= OWN_I;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= bus.if_addr;
                        mem_wdata_q <= '0;
                        mem_wstrb_q <= '0;
                        starve_cnt  <= '0;
                    end
                end
                ISSUE: begin
                    if (bus.mem_gnt) mem_req_q <= 1'b0;
                    if (owner == OWN_I && bus.if_flush) drop_i <= 1'b1;
                end
                WAIT: begin
                    if (bus.mem_rvalid)
                        drop_i <= 1'b0;
                    else if (owner == OWN_I && bus.if_flush)
                        drop_i <= 1'b1;
                end
                default: drop_i <= 1'b0;
            endcase
        end
    end

    always_comb begin
        resp          = !reset && (state == WAIT) && bus.mem_rvalid;
        bus.mem_req   = mem_req_q;
        bus.mem_we    = mem_we_q;
        bus.mem_addr  = mem_addr_q;
        bus.mem_wdata = mem_wdata_q;
        bus.mem_wstrb = mem_wstrb_q;
        bus.dm_valid  = resp && (owner == OWN_D);
        bus.if_valid  = resp && (owner == OWN_I) && !drop_i && !bus.if_flush;
        bus.dm_rdata  = bus.mem_rdata;
        bus.if_rdata  = bus.mem_rdata;
        bus.stall_f   = bus.if_req && !(resp && (owner == OWN_I) && !drop_i && !bus.if_flush);
        bus.stall_m   = bus.dm_req && !(resp && (owner == OWN_D));
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, directed multi-cycle sequences,
// then randomized traffic checked against a transaction-level reference model.
module tb_mem_port_arbiter;
    localparam int ADDR_W     = 64;
    localparam int DATA_W     = 64;
    localparam int STARVE_MAX = 4;
    localparam int RAND_CYC   = 4000;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;
    localparam logic [63:0] Z    = 64'h0;
    localparam logic [63:0] A_F0 = 64'h1000;
    localparam logic [63:0] A_F1 = 64'h1008;
    localparam logic [63:0] A_D  = 64'h2000;
    localparam logic [63:0] WD   = 64'hDEAD_BEEF;
    localparam logic [63:0] RD0  = 64'h0050_0093;
    localparam logic [63:0] RD1  = 64'h1234;
    localparam logic [7:0]  S0   = 8'h00;
    localparam logic [7:0]  SF   = 8'hFF;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        if_req;   logic [63:0] if_addr;  logic        if_flush;
        logic        dm_req;   logic        dm_we;    logic [63:0] dm_addr;
        logic [63:0] dm_wdata; logic [7:0]  dm_wstrb;
        logic        mem_gnt;  logic        mem_rvalid; logic [63:0] mem_rdata;
        logic        e_req;    logic        e_we;     logic [63:0] e_addr;
        logic [7:0]  e_strb;   logic [63:0] e_wdata;
        logic        e_iv;     logic        e_dv;     logic        e_sf;  logic e_sm;
    } vec_t;
    vec_t vt[14];

    typedef struct {
        bit          is_d;
        logic [63:0] addr;
        bit          we;
        logic [63:0] wdata;
        logic [7:0]  strb;
        int          born;
        bit          granted;
        bit          dropped;
    } txn_t;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        bus.if_req = 1'b0;  bus.if_addr = '0;  bus.if_flush = 1'b0;
        bus.dm_req = 1'b0;  bus.dm_we = 1'b0;  bus.dm_addr = '0;
        bus.dm_wdata = '0;  bus.dm_wstrb = '0;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (2) next_cycle();
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t q[$];
        txn_t t;
        int   streak;
        bit   f_act, d_act, flush, e_req, resp, e_iv, e_dv, exp_d;
        logic [63:0] f_addr, d_addr, d_wdata;
        logic [7:0]  d_strb;
        bit   d_we;

        vt[0]  = '{H,A_F0,L, L,L,Z,Z,S0, L,L,Z,   L,L,Z,S0,Z,     L,L,H,L};
        vt[1]  = '{H,A_F0,L, L,L,Z,Z,S0, H,L,Z,   H,L,A_F0,S0,Z,  L,L,H,L};
        vt[2]  = '{H,A_F0,L, L,L,Z,Z,S0, L,H,RD0, L,L,Z,S0,Z,     H,L,L,L};
        vt[3]  = '{L,Z,L,    L,L,Z,Z,S0, L,L,Z,   L,L,Z,S0,Z,     L,L,L,L};
        vt[4]  = '{H,A_F1,L, H,H,A_D,WD,SF, L,L,Z,   L,L,Z,S0,Z,     L,L,H,H};
        vt[5]  = '{H,A_F1,L, H,H,A_D,WD,SF, H,L,Z,   H,H,A_D,SF,WD,  L,L,H,H};
        vt[6]  = '{H,A_F1,L, H,H,A_D,WD,SF, L,H,Z,   L,L,Z,S0,Z,     L,H,H,L};
        vt[7]  = '{H,A_F1,L, L,L,Z,Z,S0, L,L,Z,   L,L,Z,S0,Z,     L,L,H,L};
        vt[8]  = '{H,A_F1,L, L,L,Z,Z,S0, L,L,Z,   H,L,A_F1,S0,Z,  L,L,H,L};
        vt[9]  = '{H,A_F1,L, L,L,Z,Z,S0, H,L,Z,   H,L,A_F1,S0,Z,  L,L,H,L};
        vt[10] = '{H,A_F1,L, L,L,Z,Z,S0, L,L,Z,   L,L,Z,S0,Z,     L,L,H,L};
        vt[11] = '{H,A_F1,L, L,L,Z,Z,S0, L,H,RD1, L,L,Z,S0,Z,     H,L,L,L};
        vt[12] = '{L,Z,L,    L,L,Z,Z,S0, H,H,RD1, L,L,Z,S0,Z,     L,L,L,L};
        vt[13] = '{L,Z,L,    L,L,Z,Z,S0, L,L,Z,   L,L,Z,S0,Z,     L,L,L,L};

        // Reset held three edges with both requesters active.
        idle_inputs();
        bus.if_req = 1'b1; bus.if_addr = 64'h1000;
        bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 64'h7000;
        bus.dm_wdata = 64'h77; bus.dm_wstrb = 8'h0F;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            settle();
            chk1("rst_mem_req", bus.mem_req, 1'b0);
            chk1("rst_if_valid", bus.if_valid, 1'b0);
            chk1("rst_dm_valid", bus.dm_valid, 1'b0);
            chk1("rst_stall_f", bus.stall_f, 1'b1);
            chk1("rst_stall_m", bus.stall_m, 1'b1);
            chk64("rst_mem_addr", bus.mem_addr, 64'h0);
        end
        reset = 1'b0;
        settle();
        chk1("rel1_mem_req", bus.mem_req, 1'b0);
        next_cycle();
        settle();
        chk1("rel2_mem_req", bus.mem_req, 1'b1);
        chk1("rel2_mem_we", bus.mem_we, 1'b1);
        chk64("rel2_mem_addr", bus.mem_addr, 64'h7000);

        // Vector table: lone fetch, collision, stale responses.
        do_reset();
        for (int i = 0; i < 14; i++) begin
            next_cycle();
            bus.if_req = vt[i].if_req;     bus.if_addr = vt[i].if_addr;   bus.if_flush = vt[i].if_flush;
            bus.dm_req = vt[i].dm_req;     bus.dm_we = vt[i].dm_we;       bus.dm_addr = vt[i].dm_addr;
            bus.dm_wdata = vt[i].dm_wdata; bus.dm_wstrb = vt[i].dm_wstrb;
            bus.mem_gnt = vt[i].mem_gnt;   bus.mem_rvalid = vt[i].mem_rvalid;
            bus.mem_rdata = vt[i].mem_rdata;
            settle();
            chk1("vec_mem_req", bus.mem_req, vt[i].e_req);
            if (vt[i].e_req) begin
                chk1("vec_mem_we", bus.mem_we, vt[i].e_we);
                chk64("vec_mem_addr", bus.mem_addr, vt[i].e_addr);
                chk64("vec_mem_wstrb", 64'(bus.mem_wstrb), 64'(vt[i].e_strb));
                if (vt[i].e_we) chk64("vec_mem_wdata", bus.mem_wdata, vt[i].e_wdata);
            end
            chk1("vec_if_valid", bus.if_valid, vt[i].e_iv);
            chk1("vec_dm_valid", bus.dm_valid, vt[i].e_dv);
            chk1("vec_stall_f", bus.stall_f, vt[i].e_sf);
            chk1("vec_stall_m", bus.stall_m, vt[i].e_sm);
            if (vt[i].e_iv) chk64("vec_if_rdata", bus.if_rdata, vt[i].mem_rdata);
            if (vt[i].e_dv) chk64("vec_dm_rdata", bus.dm_rdata, vt[i].mem_rdata);
        end

        // Starvation: gnt/rvalid held high throughout, so stray ones in IDLE/ISSUE must be ignored.
        do_reset();
        bus.if_req = 1'b1; bus.if_addr = 64'h8000;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 64'h9000;
        bus.mem_gnt = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'h55;
        for (int k = 0; k < 6; k++) begin
            exp_d = (k != STARVE_MAX);
            settle();
            chk1("stv_idle_req", bus.mem_req, 1'b0);
            chk1("stv_idle_dv", bus.dm_valid, 1'b0);
            chk1("stv_idle_iv", bus.if_valid, 1'b0);
            next_cycle();
            settle();
            chk1("stv_issue_req", bus.mem_req, 1'b1);
            chk64("stv_issue_addr", bus.mem_addr, exp_d ? 64'h9000 : 64'h8000);
            next_cycle();
            settle();
            chk1("stv_dm_valid", bus.dm_valid, exp_d);
            chk1("stv_if_valid", bus.if_valid, !exp_d);
            next_cycle();
        end

        // Flush during WAIT, then flush in IDLE which must not affect the new fetch.
        do_reset();
        next_cycle();
        bus.if_req = 1'b1; bus.if_addr = 64'h3000;
        settle(); chk1("fl_a_req", bus.mem_req, 1'b0);
        next_cycle(); bus.mem_gnt = 1'b1;
        settle(); chk1("fl_b_req", bus.mem_req, 1'b1); chk64("fl_b_addr", bus.mem_addr, 64'h3000);
        next_cycle(); bus.mem_gnt = 1'b0; bus.if_flush = 1'b1; bus.if_addr = 64'h4000;
        settle(); chk1("fl_c_iv", bus.if_valid, 1'b0);
        next_cycle(); bus.if_flush = 1'b0;
        settle(); chk1("fl_d_iv", bus.if_valid, 1'b0); chk1("fl_d_sf", bus.stall_f, 1'b1);
        next_cycle(); bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'hBAD;
        settle(); chk1("fl_e_iv", bus.if_valid, 1'b0); chk1("fl_e_sf", bus.stall_f, 1'b1);
        next_cycle(); bus.mem_rvalid = 1'b0; bus.if_flush = 1'b1;
        settle(); chk1("fl_f_req", bus.mem_req, 1'b0); chk1("fl_f_iv", bus.if_valid, 1'b0);
        next_cycle(); bus.if_flush = 1'b0; bus.mem_gnt = 1'b1;
        settle(); chk1("fl_g_req", bus.mem_req, 1'b1); chk64("fl_g_addr", bus.mem_addr, 64'h4000);
        next_cycle(); bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'h600D;
        settle(); chk1("fl_h_iv", bus.if_valid, 1'b1); chk64("fl_h_rdata", bus.if_rdata, 64'h600D);
        chk1("fl_h_sf", bus.stall_f, 1'b0);

        // Memory stalls grant for five cycles.
        do_reset();
        next_cycle();
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 64'h5000;
        settle(); chk1("st_a_req", bus.mem_req, 1'b0); chk1("st_a_sm", bus.stall_m, 1'b1);
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            settle();
            chk1("st_hold_req", bus.mem_req, 1'b1);
            chk64("st_hold_addr", bus.mem_addr, 64'h5000);
            chk1("st_hold_sm", bus.stall_m, 1'b1);
        end
        next_cycle(); bus.mem_gnt = 1'b1;
        settle(); chk1("st_gnt_req", bus.mem_req, 1'b1); chk64("st_gnt_addr", bus.mem_addr, 64'h5000);
        next_cycle(); bus.mem_gnt = 1'b0;
        settle(); chk1("st_wait_req", bus.mem_req, 1'b0); chk1("st_wait_sm", bus.stall_m, 1'b1);
        next_cycle(); bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'hCAFE;
        settle(); chk1("st_dv", bus.dm_valid, 1'b1); chk64("st_rdata", bus.dm_rdata, 64'hCAFE);
        chk1("st_sm", bus.stall_m, 1'b0);

        // Reset during WAIT: the late response must be ignored.
        do_reset();
        next_cycle();
        bus.if_req = 1'b1; bus.if_addr = 64'h6000;
        next_cycle(); bus.mem_gnt = 1'b1;
        settle(); chk1("rm_req", bus.mem_req, 1'b1);
        next_cycle(); bus.mem_gnt = 1'b0; reset = 1'b1;
        next_cycle(); reset = 1'b0; bus.if_req = 1'b0; bus.mem_rvalid = 1'b1;
        settle(); chk1("rm_iv", bus.if_valid, 1'b0); chk1("rm_req_after", bus.mem_req, 1'b0);
        next_cycle(); bus.mem_rvalid = 1'b0;
        settle(); chk1("rm_idle_req", bus.mem_req, 1'b0);

        // Randomized traffic against a transaction-level model.
        do_reset();
        streak = 0;
        f_act = 1'b0; d_act = 1'b0;
        f_addr = '0; d_addr = '0; d_wdata = '0; d_strb = '0; d_we = 1'b0;
        for (int cyc = 0; cyc < RAND_CYC; cyc++) begin
            next_cycle();
            flush = f_act && ($urandom_range(0, 9) == 0);
            if (flush) f_addr = {$urandom, $urandom};
            bus.if_req = f_act;   bus.if_addr = f_addr;   bus.if_flush = flush;
            bus.dm_req = d_act;   bus.dm_we = d_we;       bus.dm_addr = d_addr;
            bus.dm_wdata = d_wdata; bus.dm_wstrb = d_strb;
            bus.mem_gnt = ($urandom_range(0, 2) == 0);
            bus.mem_rvalid = ($urandom_range(0, 2) == 0);
            bus.mem_rdata = {$urandom, $urandom};
            settle();

            e_req = (q.size() > 0) && !q[0].granted && (q[0].born < cyc);
            resp  = (q.size() > 0) && q[0].granted && bus.mem_rvalid;
            e_dv  = resp && q[0].is_d;
            e_iv  = resp && !q[0].is_d && !q[0].dropped && !flush;
            chk1("rnd_mem_req", bus.mem_req, e_req);
            if (e_req) begin
                chk64("rnd_mem_addr", bus.mem_addr, q[0].addr);
                chk1("rnd_mem_we", bus.mem_we, q[0].we);
                chk64("rnd_mem_wstrb", 64'(bus.mem_wstrb), 64'(q[0].strb));
                if (q[0].we) chk64("rnd_mem_wdata", bus.mem_wdata, q[0].wdata);
            end
            chk1("rnd_if_valid", bus.if_valid, e_iv);
            chk1("rnd_dm_valid", bus.dm_valid, e_dv);
            chk1("rnd_stall_f", bus.stall_f, f_act && !e_iv);
            chk1("rnd_stall_m", bus.stall_m, d_act && !e_dv);
            if (e_iv) chk64("rnd_if_rdata", bus.if_rdata, bus.mem_rdata);
            if (e_dv) chk64("rnd_dm_rdata", bus.dm_rdata, bus.mem_rdata);

            if (q.size() > 0) begin
                if (!q[0].is_d && q[0].born < cyc && flush) q[0].dropped = 1'b1;
                if (!q[0].granted && q[0].born < cyc && bus.mem_gnt) q[0].granted = 1'b1;
                else if (resp) begin
                    void'(q.pop_front());
                    if (e_dv) d_act = 1'b0;
                    if (e_iv) f_act = 1'b0;
                end
            end else if (d_act && (!f_act || streak < STARVE_MAX)) begin
                t = '{is_d: 1'b1, addr: d_addr, we: d_we, wdata: d_wdata, strb: d_strb,
                      born: cyc, granted: 1'b0, dropped: 1'b0};
                q.push_back(t);
                streak = f_act ? ((streak < STARVE_MAX) ? streak + 1 : STARVE_MAX) : 0;
            end else if (f_act) begin
                t = '{is_d: 1'b0, addr: f_addr, we: 1'b0, wdata: 64'h0, strb: 8'h00,
                      born: cyc, granted: 1'b0, dropped: 1'b0};
                q.push_back(t);
                streak = 0;
            end

            if (!f_act && $urandom_range(0, 1) == 1) begin
                f_act = 1'b1;
                f_addr = {$urandom, $urandom};
            end
            if (!d_act && $urandom_range(0, 1) == 1) begin
                d_act = 1'b1;
                d_we = ($urandom_range(0, 1) == 1);
                d_addr = {$urandom, $urandom};
                d_wdata = {$urandom, $urandom};
                d_strb = 8'($urandom);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
